uart_frame_loader: RTL and testbench
====================================

Name: uart_frame_loader

Overview:
- Sits directly downstream of the UART receiver and consumes its byte stream (rx_done pulse plus data byte) and its error flags.
- Parses framed load packets: SYNC, ADDR, LEN, payload words, XOR checksum.
- Emits word writes into the Fibonacci microprocessor's instruction/data memory.
- Reports frame completion, checksum/line errors and inter-byte timeouts.

Parameters:
DATA_WIDTH, 8, width of each received byte.
WORD_BYTES, 4, bytes per memory word, little-endian assembly.
ADDR_WIDTH, 8, memory word address width; start address is zero-extended from the ADDR byte.
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CYCLES, 100000, maximum clk cycles allowed between bytes inside a frame.

Ports:
clk  input  1  system clock
arst_n  input  1  asynchronous active-low reset
rx_done  input  1  one-cycle pulse from the receiver; a byte is valid on data_in
data_in  input  DATA_WIDTH  received byte
rx_error  input  1  OR of the receiver's startbit_error and stopbit_error
mem_we  output  1  one-cycle word write strobe
mem_addr  output  ADDR_WIDTH  write word address
mem_wdata  output  WORD_BYTES*DATA_WIDTH  write data
frame_done  output  1  one-cycle pulse: frame received with a good checksum
frame_error  output  1  one-cycle pulse: bad checksum, or rx_error mid-frame
timeout_error  output  1  one-cycle pulse: inter-byte gap exceeded
busy  output  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset arst_n is asynchronous, active-low.
- Reset values: all outputs 0. State IDLE. Counters, word accumulator and checksum cleared.
- Byte acceptance: a byte is accepted only in a cycle with rx_done=1.
- FSM states: IDLE, ADDR, LEN, DATA, CHECK.
  - IDLE: accepted byte == SYNC_BYTE -> ADDR, clear checksum. Any other byte is discarded silently.
  - ADDR: latch start address and set checksum = byte -> LEN.
  - LEN: latch word count N, checksum ^= byte. N==0 -> CHECK (legal empty frame, no writes). Otherwise -> DATA with byte_idx=0 and word_idx=0.
  - DATA:
    - Each byte: checksum ^= byte, placed at bits [8*byte_idx +: 8] of the accumulator.
    - On byte_idx==WORD_BYTES-1: mem_we=1 in the next cycle with mem_addr = start + word_idx (mod 2^ADDR_WIDTH) and mem_wdata = completed word; word_idx increments.
    - After word N has been written -> CHECK.
  - CHECK: accepted byte == checksum -> frame_done pulse, else frame_error pulse. Either way -> IDLE.
- Latency:
  - mem_we is registered, one cycle after the rx_done of the word's last byte.
  - frame_done and frame_error are registered, one cycle after the checksum byte's rx_done.
- Words are written as they complete, before the checksum is verified. Consumers treat frame_error as "region contents invalid"; this block performs no rollback.
- mem_addr and mem_wdata hold their values between writes.
- Timeout:
  - A counter runs only in non-IDLE states. It is cleared on every accepted byte and on entry to IDLE.
  - When the count reaches TIMEOUT_CYCLES-1 without a byte: timeout_error pulse, -> IDLE, partial word discarded.
- rx_error:
  - In any non-IDLE state: frame_error pulse, -> IDLE.
  - In IDLE: ignored.
- Simultaneous events:
  - rx_error together with rx_done: the error wins and the byte is discarded.
  - rx_done in the cycle the timeout expires: the byte wins and the counter clears.
- Reset mid-frame: immediate return to IDLE. Any pending mem_we or pulse outputs are suppressed.
- Address wrap: word addresses wrap modulo 2^ADDR_WIDTH with no error.

Test Plan:
- Good frame: bytes A5,10,01,11,22,33,44,55 -> one mem_we with mem_addr=0x10 and mem_wdata=0x44332211; then frame_done=1 for one cycle; busy returns to 0.
- Bad checksum: same frame with last byte 0x54 -> mem_we still fires once, then frame_error=1, frame_done stays 0, state IDLE.
- Wrap plus multi-word: A5,FF,02, then 8 data bytes 01..08, then the correct checksum (0xFF^0x02^0x08 = 0xF5) -> writes 0x04030201@0xFF and 0x08070605@0x00, then frame_done.
- Noise and empty frame: 00,A4 in IDLE produce no activity. Then A5,20,00,20 -> frame_done with no mem_we.
- Timeout: A5,10 then silence for TIMEOUT_CYCLES cycles -> timeout_error pulse, busy=0. A following full good frame is accepted normally.
- rx_error mid-DATA, coincident with an rx_done pulse -> frame_error and no mem_we for that partial word. A subsequent arst_n pulse mid-frame clears all outputs to 0.

Source files
------------

// File: rtl/uart_frame_loader.sv
// Framed memory loader: parses SYNC, ADDR, LEN, payload words and an XOR checksum
// from a UART byte stream and emits little-endian word writes.
`timescale 1ns/1ps
module uart_frame_loader #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    WORD_BYTES     = 4,
  parameter int                    ADDR_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = 8'hA5,
  parameter int                    TIMEOUT_CYCLES = 100000
) (
  input  logic                             clk,
  input  logic                             arst_n,
  input  logic                             rx_done,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic                             rx_error,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [WORD_BYTES*DATA_WIDTH-1:0] mem_wdata,
  output logic                             frame_done,
  output logic                             frame_error,
  output logic                             timeout_error,
  output logic                             busy
);

  localparam int WW  = WORD_BYTES * DATA_WIDTH;
  localparam int BIW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_CHECK} state_t;

  state_t                r_state, w_state_nx;
  logic [ADDR_WIDTH-1:0] r_start, w_start_nx;
  logic [DATA_WIDTH-1:0] r_len, w_len_nx;
  logic [BIW-1:0]        r_bidx, w_bidx_nx;
  logic [DATA_WIDTH-1:0] r_widx, w_widx_nx, w_widx_inc;
  logic [WW-1:0]         r_acc, w_acc_nx, w_word;
  logic [DATA_WIDTH-1:0] r_csum, w_csum_nx;
  logic [TCW-1:0]        r_tcnt, w_tcnt_nx;
  logic                  r_we, w_we_nx;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nx;
  logic [WW-1:0]         r_wdata, w_wdata_nx;
  logic                  r_done, w_done_nx;
  logic                  r_ferr, w_ferr_nx;
  logic                  r_tout, w_tout_nx;

  assign w_widx_inc = r_widx + 1'b1;

  always_comb begin
    w_state_nx = r_state;
    w_start_nx = r_start;
    w_len_nx   = r_len;
    w_bidx_nx  = r_bidx;
    w_widx_nx  = r_widx;
    w_acc_nx   = r_acc;
    w_csum_nx  = r_csum;
    w_tcnt_nx  = r_tcnt;
    w_we_nx    = 1'b0;
    w_addr_nx  = r_addr;
    w_wdata_nx = r_wdata;
    w_done_nx  = 1'b0;
    w_ferr_nx  = 1'b0;
    w_tout_nx  = 1'b0;
    w_word     = r_acc;
    w_word[DATA_WIDTH*r_bidx +: DATA_WIDTH] = data_in;

    // Priority inside a frame: rx_error, then an accepted byte, then timeout expiry.
    if (r_state == S_IDLE) begin
      if (rx_done && !rx_error && (data_in == SYNC_BYTE)) begin
        w_state_nx = S_ADDR;
        w_csum_nx  = '0;
      end
    end else if (rx_error) begin
      w_state_nx = S_IDLE;
      w_ferr_nx  = 1'b1;
    end else if (rx_done) begin
      w_tcnt_nx = '0;
      w_csum_nx = r_csum ^ data_in;
      case (r_state)
        S_ADDR: begin
          w_start_nx = ADDR_WIDTH'(data_in);
          w_csum_nx  = data_in;
          w_state_nx = S_LEN;
        end
        S_LEN: begin
          w_len_nx   = data_in;
          w_bidx_nx  = '0;
          w_widx_nx  = '0;
          w_acc_nx   = '0;
          w_state_nx = (data_in == '0) ? S_CHECK : S_DATA;
        end
        S_DATA: begin
          w_acc_nx = w_word;
          if (r_bidx == BIW'(WORD_BYTES - 1)) begin
            w_we_nx    = 1'b1;
            w_addr_nx  = r_start + ADDR_WIDTH'(r_widx);
            w_wdata_nx = w_word;
            w_widx_nx  = w_widx_inc;
            w_bidx_nx  = '0;
            if (w_widx_inc == r_len) w_state_nx = S_CHECK;
          end else begin
            w_bidx_nx = r_bidx + 1'b1;
          end
        end
        S_CHECK: begin
          if (data_in == r_csum) w_done_nx = 1'b1;
          else                   w_ferr_nx = 1'b1;
          w_state_nx = S_IDLE;
        end
        default: w_state_nx = S_IDLE;
      endcase
    end else if (r_tcnt == TCW'(TIMEOUT_CYCLES - 1)) begin
      w_tout_nx  = 1'b1;
      w_state_nx = S_IDLE;
    end else begin
      w_tcnt_nx = r_tcnt + 1'b1;
    end

    if (w_state_nx == S_IDLE) begin
      w_tcnt_nx = '0;
      w_bidx_nx = '0;
      w_widx_nx = '0;
      w_acc_nx  = '0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= S_IDLE;
      r_start <= '0;
      r_len   <= '0;
      r_bidx  <= '0;
      r_widx  <= '0;
      r_acc   <= '0;
      r_csum  <= '0;
      r_tcnt  <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      r_tout  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_start <= w_start_nx;
      r_len   <= w_len_nx;
      r_bidx  <= w_bidx_nx;
      r_widx  <= w_widx_nx;
      r_acc   <= w_acc_nx;
      r_csum  <= w_csum_nx;
      r_tcnt  <= w_tcnt_nx;
      r_we    <= w_we_nx;
      r_addr  <= w_addr_nx;
      r_wdata <= w_wdata_nx;
      r_done  <= w_done_nx;
      r_ferr  <= w_ferr_nx;
      r_tout  <= w_tout_nx;
    end
  end

  assign mem_we        = r_we;
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_wdata;
  assign frame_done    = r_done;
  assign frame_error   = r_ferr;
  assign timeout_error = r_tout;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboarded bench for uart_frame_loader: expected writes and frame outcomes are
// queued as bytes are driven and matched by a negedge monitor.
`timescale 1ns/1ps
module tb_uart_frame_loader;

  localparam int TO = 64;
  localparam logic [2:0] EV_DONE = 3'b001;
  localparam logic [2:0] EV_FERR = 3'b010;
  localparam logic [2:0] EV_TOUT = 3'b100;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        rx_done = 1'b0;
  logic        rx_error = 1'b0;
  logic [7:0]  data_in = '0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        frame_done, frame_error, timeout_error, busy;

  int checks = 0;
  int errors = 0;

  logic [39:0] exp_wr[$];
  logic [2:0]  exp_ev[$];
  logic [7:0]  tx[$];
  logic [39:0] mon_w;
  logic [2:0]  mon_e, mon_x;

  uart_frame_loader #(
    .DATA_WIDTH(8),
    .WORD_BYTES(4),
    .ADDR_WIDTH(8),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .arst_n(arst_n),
    .rx_done(rx_done),
    .data_in(data_in),
    .rx_error(rx_error),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .frame_done(frame_done),
    .frame_error(frame_error),
    .timeout_error(timeout_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (arst_n) begin
      if (mem_we) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL mem_write: unexpected write addr=%h data=%h", mem_addr, mem_wdata);
        end else begin
          mon_w = exp_wr.pop_front();
          if ({mem_addr, mem_wdata} !== mon_w) begin
            errors++;
            $display("FAIL mem_write: got addr=%h data=%h, expected addr=%h data=%h",
                     mem_addr, mem_wdata, mon_w[39:32], mon_w[31:0]);
          end
        end
      end
      mon_e = {timeout_error, frame_error, frame_done};
      if (mon_e != 3'b000) begin
        checks++;
        if (exp_ev.size() == 0) begin
          errors++;
          $display("FAIL frame_event: unexpected {tout,ferr,done}=%b", mon_e);
        end else begin
          mon_x = exp_ev.pop_front();
          if (mon_e !== mon_x) begin
            errors++;
            $display("FAIL frame_event: got {tout,ferr,done}=%b, expected %b", mon_e, mon_x);
          end
        end
      end
    end
  end

  // Caller is at a negedge; the byte is seen at the following posedge.
  task automatic send_byte(input logic [7:0] b, input logic err);
    rx_done  = 1'b1;
    data_in  = b;
    rx_error = err;
    @(negedge clk);
    rx_done  = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic send_tx(input int max_gap);
    foreach (tx[i]) begin
      send_byte(tx[i], 1'b0);
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (exp_wr.size() == 0 && exp_ev.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== 41'd0) begin
      errors++;
      $display("FAIL reset_mem: got we=%b addr=%h data=%h, expected all 0", mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if ({frame_done, frame_error, timeout_error, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got {done,ferr,tout,busy}=%b, expected 0000",
               {frame_done, frame_error, timeout_error, busy});
    end
    arst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    bit ok;
    exp_wr.push_back({8'h10, 32'h44332211});
    exp_ev.push_back(EV_DONE);
    tx = {8'hA5, 8'h10, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_tx(0);
    wait_drain(ok);
    checks++;
    if (!ok || busy !== 1'b0) begin
      errors++;
      $display("FAIL good_frame: drained=%0d busy=%b, expected drained=1 busy=0", ok, busy);
    end
    checks++;
    if (mem_addr !== 8'h10 || mem_wdata !== 32'h44332211) begin
      errors++;
      $display("FAIL write_hold: got addr=%h data=%h, expected 10/44332211", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_bad_checksum();
    bit ok;
    exp_wr.push_back({8'h10, 32'h44332211});
    exp_ev.push_back(EV_FERR);
    tx = {8'hA5, 8'h10, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h54};
    send_tx(1);
    wait_drain(ok);
    checks++;
    if (!ok || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_checksum: drained=%0d busy=%b, expected drained=1 busy=0", ok, busy);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    exp_wr.push_back({8'hFF, 32'h04030201});
    exp_wr.push_back({8'h00, 32'h08070605});
    exp_ev.push_back(EV_DONE);
    tx = {8'hA5, 8'hFF, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
          8'h05, 8'h06, 8'h07, 8'h08, 8'hF5};
    send_tx(2);
    wait_drain(ok);
    checks++;
    if (!ok || busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_multiword: drained=%0d busy=%b, expected drained=1 busy=0", ok, busy);
    end
  endtask

  task automatic test_noise_empty();
    bit ok;
    send_byte(8'h00, 1'b0);
    send_byte(8'hA4, 1'b0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL noise_idle: busy=%b, expected 0", busy);
    end
    exp_ev.push_back(EV_DONE);
    send_byte(8'hA5, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL sync_busy: busy=%b, expected 1", busy);
    end
    tx = {8'h20, 8'h00, 8'h20};
    send_tx(0);
    wait_drain(ok);
    checks++;
    if (!ok || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_frame: drained=%0d busy=%b, expected drained=1 busy=0", ok, busy);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    exp_ev.push_back(EV_TOUT);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h10, 1'b0);
    n = 0;
    while (!timeout_error && n < 3 * TO) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != TO) begin
      errors++;
      $display("FAIL timeout_latency: pulse after %0d idle cycles, expected %0d", n, TO);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: busy=%b, expected 0", busy);
    end
    exp_wr.push_back({8'h10, 32'h44332211});
    exp_ev.push_back(EV_DONE);
    tx = {8'hA5, 8'h10, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_tx(0);
    wait_drain(ok);
    checks++;
    if (!ok || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_timeout: drained=%0d busy=%b, expected drained=1 busy=0", ok, busy);
    end
  endtask

  // A byte landing exactly on the expiry cycle must keep the frame alive.
  task automatic test_timeout_race();
    bit ok;
    exp_wr.push_back({8'h10, 32'h44332211});
    exp_ev.push_back(EV_DONE);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h10, 1'b0);
    repeat (TO - 1) @(negedge clk);
    send_byte(8'h01, 1'b0);
    checks++;
    if (busy !== 1'b1 || timeout_error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_race: busy=%b tout=%b, expected busy=1 tout=0", busy, timeout_error);
    end
    tx = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_tx(0);
    wait_drain(ok);
    checks++;
    if (!ok || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_race_frame: drained=%0d busy=%b, expected drained=1 busy=0", ok, busy);
    end
  endtask

  task automatic test_rx_error_and_reset();
    bit ok;
    exp_ev.push_back(EV_FERR);
    tx = {8'hA5, 8'h30, 8'h01, 8'h11, 8'h22};
    send_tx(1);
    send_byte(8'h33, 1'b1);
    wait_drain(ok);
    checks++;
    if (!ok || busy !== 1'b0) begin
      errors++;
      $display("FAIL rx_error: drained=%0d busy=%b, expected drained=1 busy=0", ok, busy);
    end
    tx = {8'hA5, 8'h40, 8'h01, 8'h11, 8'h22, 8'h33};
    send_tx(0);
    rx_done = 1'b1;
    data_in = 8'h44;
    @(posedge clk);
    #1;
    arst_n  = 1'b0;
    rx_done = 1'b0;
    #1;
    checks++;
    if ({mem_we, mem_addr, mem_wdata, frame_done, frame_error, timeout_error, busy} !== 45'd0) begin
      errors++;
      $display("FAIL midframe_reset: got we=%b addr=%h data=%h flags=%b, expected all 0",
               mem_we, mem_addr, mem_wdata, {frame_done, frame_error, timeout_error, busy});
    end
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0]  addr, n, cs, d;
    logic [31:0] word;
    bit bad;
    for (int f = 0; f < 6; f++) begin
      addr = 8'($urandom);
      n    = 8'($urandom_range(3, 0));
      bad  = ($urandom_range(3, 0) == 0);
      tx   = {8'hA5, addr, n};
      cs   = addr ^ n;
      for (int w = 0; w < int'(n); w++) begin
        word = '0;
        for (int b = 0; b < 4; b++) begin
          d = 8'($urandom);
          tx.push_back(d);
          cs ^= d;
          word[8*b +: 8] = d;
        end
        exp_wr.push_back({addr + 8'(w), word});
      end
      tx.push_back(bad ? ~cs : cs);
      exp_ev.push_back(bad ? EV_FERR : EV_DONE);
      send_tx(0);
    end
    wait_drain(ok);
    checks++;
    if (!ok || busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back: drained=%0d pending_wr=%0d pending_ev=%0d busy=%b",
               ok, exp_wr.size(), exp_ev.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_wrap();
    test_noise_empty();
    test_timeout();
    test_timeout_race();
    test_rx_error_and_reset();
    test_good_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
